// File: rtl/spi_horizontal_line.sv
`default_nettype none
// ============================================================================
//  Module      : spi_horizontal_line
//  Description : SPI command sequencer that draws a single-colour horizontal
//                line on an ILI9341/ST7789-class TFT panel. A start pulse sends
//                the column-address set (X1..X2), the page-address set (Y..Y),
//                the memory-write command and then (X2-X1+1) RGB565 pixels.
//                It then raises a one-cycle completion pulse.
//                The SPI bit clock is i_clk itself. The board derives SCK from
//                i_clk so that the panel samples o_mosi mid-period.
//  Ports       : i_clk   - system clock / SPI bit clock
//                i_rst   - synchronous active-high reset
//                i_start - start request (accepted only when idle)
//                o_mosi  - serial data, MSB first
//                o_dc    - 0 = command byte, 1 = parameter / pixel byte
//                o_cs    - chip select, active low
//                o_done  - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_horizontal_line #(
   parameter int unsigned DELAY = 20,
   parameter logic [15:0] X1    = 16'd0,
   parameter logic [15:0] X2    = 16'd239,
   parameter logic [15:0] Y     = 16'd0,
   parameter logic [15:0] COLOR = 16'hFFFF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   output logic o_mosi,
   output logic o_dc,
   output logic o_cs,
   output logic o_done
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_LOAD  = 3'd1;
   localparam logic [2:0] c_SHIFT = 3'd2;
   localparam logic [2:0] c_GAP   = 3'd3;
   localparam logic [2:0] c_DONE  = 3'd4;

   // Byte indices 0..10 are the fixed header; index 11 is the pixel phase,
   // where lo_q selects the colour half and pix_q counts pixels.
   localparam logic [3:0]  c_IDX_PIX  = 4'd11;
   localparam logic [15:0] c_PIX_LAST = X2 - X1;

   localparam bit          c_HAS_GAP  = (DELAY > 0);
   localparam int unsigned c_GW       = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((DELAY > 0) ? (DELAY - 1) : 0);

   logic [2:0]      state_q, state_d;
   logic [3:0]      idx_q,   idx_d;
   logic            lo_q,    lo_d;
   logic [15:0]     pix_q,   pix_d;
   logic [2:0]      bit_q,   bit_d;
   logic [c_GW-1:0] gap_q,   gap_d;
   logic [7:0]      sh_q,    sh_d;
   logic            mosi_q,  mosi_d;
   logic            dc_q,    dc_d;
   logic            cs_q,    cs_d;
   logic            done_q,  done_d;

   logic [7:0]      w_byte;
   logic            w_dc;
   logic            w_last;
   logic            w_adv;

   // Byte to transmit for the current stream position.
   always_comb begin
      w_byte = 8'h00;
      case (idx_q)
         4'd0:    w_byte = 8'h2A;
         4'd1:    w_byte = X1[15:8];
         4'd2:    w_byte = X1[7:0];
         4'd3:    w_byte = X2[15:8];
         4'd4:    w_byte = X2[7:0];
         4'd5:    w_byte = 8'h2B;
         4'd6:    w_byte = Y[15:8];
         4'd7:    w_byte = Y[7:0];
         4'd8:    w_byte = Y[15:8];
         4'd9:    w_byte = Y[7:0];
         4'd10:   w_byte = 8'h2C;
         default: w_byte = lo_q ? COLOR[7:0] : COLOR[15:8];
      endcase
   end

   // Only the three command opcodes are sent with D/C low.
   assign w_dc   = !((idx_q == 4'd0) || (idx_q == 4'd5) || (idx_q == 4'd10));
   assign w_last = (idx_q == c_IDX_PIX) && lo_q && (pix_q == c_PIX_LAST);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      pix_d   = pix_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      sh_d    = sh_q;
      mosi_d  = mosi_q;
      dc_d    = dc_q;
      cs_d    = cs_q;
      done_d  = 1'b0;
      w_adv   = 1'b0;

      case (state_q)
         c_IDLE: begin
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            // o_done is still visible this cycle; a start coincident with
            // it belongs to the finished run and is dropped.
            if (i_start && !done_q) begin
               idx_d   = 4'd0;
               lo_d    = 1'b0;
               pix_d   = 16'd0;
               state_d = c_LOAD;
            end
         end

         c_LOAD: begin
            cs_d    = 1'b0;
            dc_d    = w_dc;
            mosi_d  = w_byte[7];
            sh_d    = {w_byte[6:0], 1'b0};
            bit_d   = 3'd0;
            state_d = c_SHIFT;
         end

         c_SHIFT: begin
            cs_d   = 1'b0;
            mosi_d = sh_q[7];
            sh_d   = {sh_q[6:0], 1'b0};
            bit_d  = bit_q + 3'd1;
            // Seventh shift cycle presents bit0; LOAD already sent bit7.
            if (bit_q == 3'd6) begin
               if (c_HAS_GAP) begin
                  gap_d   = '0;
                  state_d = c_GAP;
               end else if (w_last) begin
                  state_d = c_DONE;
               end else begin
                  w_adv   = 1'b1;
                  state_d = c_LOAD;
               end
            end
         end

         c_GAP: begin
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            if (gap_q == c_GAP_LAST) begin
               if (w_last) begin
                  state_d = c_DONE;
               end else begin
                  w_adv   = 1'b1;
                  state_d = c_LOAD;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         c_DONE: begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            state_d = c_IDLE;
         end

         default: begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = c_IDLE;
         end
      endcase

      // Step to the next byte: header index first, then alternate
      // high/low colour bytes, counting a pixel after each low byte.
      if (w_adv) begin
         if (idx_q != c_IDX_PIX) begin
            idx_d = idx_q + 4'd1;
         end else begin
            lo_d = !lo_q;
            if (lo_q) begin
               pix_d = pix_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= c_IDLE;
         idx_q   <= 4'd0;
         lo_q    <= 1'b0;
         pix_q   <= 16'd0;
         bit_q   <= 3'd0;
         gap_q   <= '0;
         sh_q    <= 8'h00;
         mosi_q  <= 1'b0;
         dc_q    <= 1'b0;
         cs_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         pix_q   <= pix_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         sh_q    <= sh_d;
         mosi_q  <= mosi_d;
         dc_q    <= dc_d;
         cs_q    <= cs_d;
         done_q  <= done_d;
      end
   end

   assign o_mosi = mosi_q;
   assign o_dc   = dc_q;
   assign o_cs   = cs_q;
   assign o_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_horizontal_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_horizontal_line
//  Description : Scoreboard bench for spi_horizontal_line. Two instances:
//                A = DELAY 20, X1 5, X2 10, Y 5, COLOR FFFF
//                B = DELAY 0,  X1 0, X2 0,  Y 0x0102, COLOR A55A
//                Stimulus pushes the expected byte stream, first chip-select
//                fall cycle and done latency. A negedge monitor decodes the
//                SPI stream and pops/compares the expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_horizontal_line;

   localparam int          A_DELAY = 20;
   localparam int          A_NPIX  = 6;
   localparam int          A_LAT   = 644;   // 23 bytes * 28 cycles
   localparam int          A_NBY   = 23;
   localparam logic [15:0] A_COLOR = 16'hFFFF;
   localparam logic [7:0]  A_HDR [11] = '{8'h2A, 8'h00, 8'h05, 8'h00, 8'h0A,
                                          8'h2B, 8'h00, 8'h05, 8'h00, 8'h05, 8'h2C};

   localparam int          B_DELAY = 0;
   localparam int          B_NPIX  = 1;
   localparam int          B_LAT   = 104;   // 13 bytes * 8 cycles
   localparam int          B_NBY   = 13;
   localparam logic [15:0] B_COLOR = 16'hA55A;
   localparam logic [7:0]  B_HDR [11] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h00,
                                          8'h2B, 8'h01, 8'h02, 8'h01, 8'h02, 8'h2C};

   // D/C per header byte, bit i = byte i: commands at 0, 5, 10.
   localparam logic [10:0] HDR_DC = 11'b01111011110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1, start_a = 1'b0, mosi_a, dc_a, cs_a, done_a;
   logic rst_b = 1'b1, start_b = 1'b0, mosi_b, dc_b, cs_b, done_b;

   spi_horizontal_line #(
      .DELAY(20), .X1(16'd5), .X2(16'd10), .Y(16'd5), .COLOR(16'hFFFF)
   ) u_dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_start(start_a),
      .o_mosi(mosi_a), .o_dc(dc_a), .o_cs(cs_a), .o_done(done_a)
   );

   spi_horizontal_line #(
      .DELAY(0), .X1(16'd0), .X2(16'd0), .Y(16'h0102), .COLOR(16'hA55A)
   ) u_dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_start(start_b),
      .o_mosi(mosi_b), .o_dc(dc_b), .o_cs(cs_b), .o_done(done_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard queues, one set per instance.
   logic [8:0] bq0[$], bq1[$];   // {dc, byte}
   int         fq0[$], fq1[$];   // expected cycle of first cs fall
   int         lq0[$], lq1[$];   // expected done latency from that fall

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_run(input int d, input int c0);
      logic [15:0] col;
      int          np;
      col = (d == 0) ? A_COLOR : B_COLOR;
      np  = (d == 0) ? A_NPIX : B_NPIX;
      for (int i = 0; i < 11; i++) begin
         if (d == 0) bq0.push_back({HDR_DC[i], A_HDR[i]});
         else        bq1.push_back({HDR_DC[i], B_HDR[i]});
      end
      for (int p = 0; p < np; p++) begin
         if (d == 0) begin
            bq0.push_back({1'b1, col[15:8]});
            bq0.push_back({1'b1, col[7:0]});
         end else begin
            bq1.push_back({1'b1, col[15:8]});
            bq1.push_back({1'b1, col[7:0]});
         end
      end
      if (d == 0) begin fq0.push_back(c0 + 1); lq0.push_back(A_LAT); end
      else        begin fq1.push_back(c0 + 1); lq1.push_back(B_LAT); end
   endtask

   function automatic logic [31:0] pop_byte(input int d);
      if (d == 0) return (bq0.size() > 0) ? {23'd0, bq0.pop_front()} : 32'hDEAD_BEEF;
      else        return (bq1.size() > 0) ? {23'd0, bq1.pop_front()} : 32'hDEAD_BEEF;
   endfunction

   function automatic int pop_fall(input int d);
      if (d == 0) return (fq0.size() > 0) ? fq0.pop_front() : -1;
      else        return (fq1.size() > 0) ? fq1.pop_front() : -1;
   endfunction

   function automatic int pop_lat(input int d);
      if (d == 0) return (lq0.size() > 0) ? lq0.pop_front() : -1;
      else        return (lq1.size() > 0) ? lq1.pop_front() : -1;
   endfunction

   // ---------------------------------------------------------------- monitor
   bit         busy   [2];
   int         bitcnt [2];
   logic [7:0] acc    [2];
   logic       dcs    [2];
   int         hicnt  [2];
   int         fallc  [2];
   int         nby    [2];

   task automatic mon(input int d, input logic cs, input logic mosi, input logic dc,
                      input logic done, input logic rst);
      if (rst) begin
         busy[d]   = 1'b0;
         bitcnt[d] = 0;
         hicnt[d]  = 0;
         return;
      end
      if (cs === 1'b0) begin
         if (!busy[d]) begin
            busy[d]  = 1'b1;
            fallc[d] = cyc;
            nby[d]   = 0;
            check($sformatf("dut%0d first cs fall cycle", d), cyc, pop_fall(d));
         end else if (bitcnt[d] == 0 && hicnt[d] != 0) begin
            check($sformatf("dut%0d gap length before byte %0d", d, nby[d]),
                  hicnt[d], (d == 0) ? A_DELAY : B_DELAY);
         end
         hicnt[d] = 0;
         if (bitcnt[d] == 0) dcs[d] = dc;
         acc[d] = {acc[d][6:0], mosi};
         bitcnt[d]++;
         if (bitcnt[d] == 8) begin
            bitcnt[d] = 0;
            check($sformatf("dut%0d byte %0d {dc,data}", d, nby[d]),
                  {23'd0, dcs[d], acc[d]}, pop_byte(d));
            nby[d]++;
         end
      end else if (busy[d]) begin
         if (hicnt[d] == 0)
            check($sformatf("dut%0d cs window bit count at rise", d), bitcnt[d], 0);
         check($sformatf("dut%0d mosi while cs high", d), mosi, 0);
         hicnt[d]++;
      end
      if (done === 1'b1) begin
         check($sformatf("dut%0d done inside a run", d), busy[d], 1);
         check($sformatf("dut%0d done latency", d), cyc - fallc[d], pop_lat(d));
         check($sformatf("dut%0d bytes per run", d), nby[d], (d == 0) ? A_NBY : B_NBY);
         check($sformatf("dut%0d cs with done", d), cs, 1);
         busy[d]  = 1'b0;
         hicnt[d] = 0;
      end
   endtask

   always @(negedge clk) begin
      mon(0, cs_a, mosi_a, dc_a, done_a, rst_a);
      mon(1, cs_b, mosi_b, dc_b, done_b, rst_b);
   end

   // --------------------------------------------------------------- stimulus
   task automatic set_start(input int d, input logic v);
      if (d == 0) start_a = v; else start_b = v;
   endtask

   task automatic start_run(input int d);
      @(posedge clk); #1;
      set_start(d, 1'b1);
      @(posedge clk); #1;
      set_start(d, 1'b0);
      push_run(d, cyc);
   endtask

   task automatic wait_done(input int d, input int budget);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (((d == 0) ? done_a : done_b) !== 1'b1 && n < budget);
      check($sformatf("dut%0d done within %0d cycles", d, budget),
            (d == 0) ? done_a : done_b, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset cs_a",   cs_a,   1);
      check("reset mosi_a", mosi_a, 0);
      check("reset dc_a",   dc_a,   0);
      check("reset done_a", done_a, 0);
      check("reset cs_b",   cs_b,   1);
      check("reset mosi_b", mosi_b, 0);
      check("reset dc_b",   dc_b,   0);
      check("reset done_b", done_b, 0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (4) @(posedge clk);

      // Full line on A; a start during byte 3 must not disturb it.
      start_run(0);
      repeat (3 * 28) @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      wait_done(0, 1000);

      // Start held from the done cycle: first sample ignored, next accepted.
      start_a = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start_a = 1'b0;
      push_run(0, cyc);
      wait_done(0, 1000);

      // Reset in the middle of the pixel phase, then a clean rerun.
      start_run(0);
      repeat (11 * 28 + 40) @(posedge clk);
      #1 rst_a = 1'b1;
      bq0.delete();
      fq0.delete();
      lq0.delete();
      @(posedge clk); #1;
      check("mid-run reset cs_a",   cs_a,   1);
      check("mid-run reset done_a", done_a, 0);
      check("mid-run reset mosi_a", mosi_a, 0);
      rst_a = 1'b0;
      repeat (30) @(posedge clk);
      start_run(0);
      wait_done(0, 1000);

      // Zero-gap single-pixel line on B, twice.
      start_run(1);
      wait_done(1, 300);
      repeat (5) @(posedge clk);
      start_run(1);
      wait_done(1, 300);

      repeat (40) @(posedge clk);
      #1;
      check("dut0 bytes outstanding", bq0.size(), 0);
      check("dut1 bytes outstanding", bq1.size(), 0);
      check("dut0 done outstanding",  lq0.size(), 0);
      check("dut1 done outstanding",  lq1.size(), 0);
      check("dut0 idle at end",       busy[0],    0);
      check("dut1 idle at end",       busy[1],    0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
